// File: rtl/sub_pkg.sv
// Shared types and helpers for the digit-serial subtractor.
package sub_pkg;

  // Operation sequencing: wait for operands, walk the digits, present the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of digit cycles per operation; guarded so a bad DIGIT cannot divide by zero
  // before the elaboration check in the top level reports it.
  function automatic int ndig(input int width, input int digit);
    if (digit < 1) begin
      return 1;
    end else begin
      return width / digit;
    end
  endfunction

endpackage

// File: rtl/sub_digit_slice.sv
// One digit of A + ~B + cin as a ripple chain of full adders.
module sub_digit_slice #(
  parameter int DIGIT = 8
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             cin,
  output logic [DIGIT-1:0] s_d,
  output logic             cout
);

  logic [DIGIT-1:0] b_n_s;
  logic [DIGIT:0]   c_s;

  assign b_n_s  = ~b_d;
  assign c_s[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign s_d[i]   = a_d[i] ^ b_n_s[i] ^ c_s[i];
    assign c_s[i+1] = (a_d[i] & b_n_s[i]) | (a_d[i] & c_s[i]) | (b_n_s[i] & c_s[i]);
  end

  assign cout = c_s[DIGIT];

endmodule

// File: rtl/digit_serial_subtractor.sv
// Multi-cycle a - b - bin, DIGIT bits per cycle, with valid/ready on both sides.
module digit_serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int NDIG = ndig(WIDTH, DIGIT);
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  if ((DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
    $error("digit_serial_subtractor: WIDTH must be a positive multiple of DIGIT");
  end

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic             carry_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] diff_r;
  logic             bout_r;
  logic             ovf_r;
  logic             in_ready_r;
  logic             out_valid_r;

  logic [DIGIT-1:0] a_dig_s;
  logic [DIGIT-1:0] b_dig_s;
  logic [DIGIT-1:0] sum_s;
  logic             cout_s;
  logic             last_s;

  // Select the operand digit addressed by the counter and flag the final digit.
  always_comb begin
    a_dig_s = a_r[int'(cnt_r)*DIGIT +: DIGIT];
    b_dig_s = b_r[int'(cnt_r)*DIGIT +: DIGIT];
    if (cnt_r == CW'(NDIG - 1)) begin
      last_s = 1'b1;
    end else begin
      last_s = 1'b0;
    end
  end

  sub_digit_slice #(.DIGIT(DIGIT)) u_slice (
    .a_d  (a_dig_s),
    .b_d  (b_dig_s),
    .cin  (carry_r),
    .s_d  (sum_s),
    .cout (cout_s)
  );

  // Control FSM, digit counter, operand capture and registered result/handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      carry_r     <= 1'b0;
      a_r         <= '0;
      b_r         <= '0;
      diff_r      <= '0;
      bout_r      <= 1'b0;
      ovf_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r        <= a;
            b_r        <= b;
            carry_r    <= ~bin;
            cnt_r      <= '0;
            in_ready_r <= 1'b0;
            state_r    <= RUN;
          end
        end
        RUN: begin
          diff_r[int'(cnt_r)*DIGIT +: DIGIT] <= sum_s;
          carry_r <= cout_s;
          if (last_s) begin
            // Subtraction overflows only when operand signs differ and the
            // result sign departs from the minuend's.
            bout_r      <= ~cout_s;
            ovf_r       <= (a_r[WIDTH-1] != b_r[WIDTH-1]) && (sum_s[DIGIT-1] != a_r[WIDTH-1]);
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign diff      = diff_r;
  assign bout      = bout_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_digit_serial_subtractor.sv
// Self-checking bench: directed table, handshake corner cases and randomized ops.
module tb_digit_serial_subtractor;

  localparam int WIDTH = 32;
  localparam int DIGIT = 8;
  localparam int NDIG  = WIDTH / DIGIT;
  localparam int BOUND = 50;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  int tests_run = 0;
  int failed    = 0;

  digit_serial_subtractor #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic [31:0] diff;
    logic        bout;
    logic        ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: plain wide arithmetic on the unsigned and signed readings of the operands.
  function automatic void model(input logic [31:0] ma, input logic [31:0] mb, input logic mbin,
                                output logic [31:0] md, output logic mbo, output logic mov);
    logic [32:0] u;
    longint s;
    u   = {1'b0, ma} - {1'b0, mb} - {32'd0, mbin};
    md  = u[31:0];
    mbo = u[32];
    s   = longint'($signed(ma)) - longint'($signed(mb)) - longint'({31'd0, mbin});
    mov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  // Accept one operation, scramble the inputs afterwards, wait for out_valid.
  task automatic start_op(input logic [31:0] ta, input logic [31:0] tb, input logic tbin,
                          output int lat);
    int n;
    n = 0;
    while (!in_ready && n < BOUND) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready_wait", {63'd0, in_ready}, 64'd1);
    a = ta; b = tb; bin = tbin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; bin = 1'($urandom_range(1, 0));
    lat = 0;
    while (!out_valid && lat < BOUND) begin
      @(posedge clk); #1; lat++;
    end
    check("out_valid_wait", {63'd0, out_valid}, 64'd1);
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_drop", {63'd0, out_valid}, 64'd0);
    check("in_ready_back", {63'd0, in_ready}, 64'd1);
  endtask

  task automatic run_vec(input string name, input logic [31:0] ta, input logic [31:0] tb,
                         input logic tbin, input logic [31:0] ed, input logic ebo, input logic eov);
    int lat;
    start_op(ta, tb, tbin, lat);
    check({name, "_lat"}, 64'(lat), 64'(NDIG));
    check({name, "_diff"}, {32'd0, diff}, {32'd0, ed});
    check({name, "_bout"}, {63'd0, bout}, {63'd0, ebo});
    check({name, "_ovf"}, {63'd0, ovf}, {63'd0, eov});
    finish_op();
  endtask

  initial begin
    logic [31:0] md;
    logic        mbo;
    logic        mov;
    int          lat;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rbin;

    vecs[0] = '{32'h00000005, 32'h00000003, 1'b0, 32'h00000002, 1'b0, 1'b0};
    vecs[1] = '{32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0};
    vecs[2] = '{32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1};
    vecs[3] = '{32'h12345678, 32'h12345678, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
    vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h00000000, 1'b0, 1'b0};
    vecs[5] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b1};
    vecs[6] = '{32'h00000000, 32'h00000000, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
    vecs[7] = '{32'h00000100, 32'h00000001, 1'b0, 32'h000000FF, 1'b0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; bin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_diff", {32'd0, diff}, 64'd0);
    check("rst_bout", {63'd0, bout}, 64'd0);
    check("rst_ovf", {63'd0, ovf}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 8; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bin,
              vecs[i].diff, vecs[i].bout, vecs[i].ovf);
    end

    // Result holds under back-pressure while inputs and in_valid wiggle
    start_op(32'h00000005, 32'h00000003, 1'b0, lat);
    for (int i = 0; i < 10; i++) begin
      a = $urandom; b = $urandom; bin = 1'($urandom_range(1, 0));
      in_valid = ~in_valid;
      @(posedge clk); #1;
      check("hold_diff", {32'd0, diff}, 64'h2);
      check("hold_bout", {63'd0, bout}, 64'd0);
      check("hold_ovf", {63'd0, ovf}, 64'd0);
      check("hold_in_ready", {63'd0, in_ready}, 64'd0);
      check("hold_out_valid", {63'd0, out_valid}, 64'd1);
    end
    in_valid = 1'b0;
    finish_op();
    @(posedge clk); #1;
    check("no_second_accept", {63'd0, in_ready}, 64'd1);

    // out_ready while idle must not disturb anything
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("idle_out_ready", {63'd0, out_valid}, 64'd0);

    // Reset in the second RUN cycle aborts cleanly
    a = 32'h00000005; b = 32'h00000003; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", {63'd0, out_valid}, 64'd0);
    check("abort_in_ready", {63'd0, in_ready}, 64'd1);
    check("abort_diff", {32'd0, diff}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_vec("after_abort", 32'h00000005, 32'h00000003, 1'b0, 32'h00000002, 1'b0, 1'b0);

    // Randomized operations against the arithmetic model
    for (int i = 0; i < 150; i++) begin
      ra = $urandom; rb = $urandom; rbin = 1'($urandom_range(1, 0));
      if (i % 5 == 0) rb = ra;
      if (i % 7 == 0) ra = {ra[31], 31'h0};
      model(ra, rb, rbin, md, mbo, mov);
      start_op(ra, rb, rbin, lat);
      check("rnd_lat", 64'(lat), 64'(NDIG));
      check("rnd_diff", {32'd0, diff}, {32'd0, md});
      check("rnd_bout", {63'd0, bout}, {63'd0, mbo});
      check("rnd_ovf", {63'd0, ovf}, {63'd0, mov});
      repeat ($urandom_range(2, 0)) begin
        @(posedge clk); #1;
      end
      finish_op();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
